// File: rtl/prisc_pkg.sv
// Shared encodings for the pRISC execute controller: opcodes, ALU op codes,
// FSM state codes, instruction field positions and flag bit indices.
package prisc_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b000001;
  localparam logic [5:0] OPC_BR    = 6'b000010;
  localparam logic [5:0] OPC_BZ    = 6'b000011;
  localparam logic [5:0] OPC_BNZ   = 6'b000100;
  localparam logic [5:0] OPC_BLTZ  = 6'b000101;
  localparam logic [5:0] OPC_BCY   = 6'b000110;
  localparam logic [5:0] OPC_HALT  = 6'b111111;

  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_COMP = 4'b0101;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam int OPC_LSB   = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int SHAMT_LSB = 6;
  localparam int FUNC_LSB  = 0;
  localparam int IMM_LSB   = 0;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [3:0]  func;
    logic [15:0] imm;
  } instr_fields_t;

  function automatic instr_fields_t decode_fields(input logic [31:0] ir);
    instr_fields_t f;
    f.opcode = ir[OPC_LSB +: 6];
    f.rs     = ir[RS_LSB +: 5];
    f.rt     = ir[RT_LSB +: 5];
    f.shamt  = ir[SHAMT_LSB +: 5];
    f.func   = ir[FUNC_LSB +: 4];
    f.imm    = ir[IMM_LSB +: 16];
    return f;
  endfunction

  // Shift ops occupy the whole 1xxx space; the rest are enumerated.
  function automatic logic func_is_legal(input logic [3:0] func);
    return func[3] || (func == ALU_ADD) || (func == ALU_AND) ||
           (func == ALU_XOR) || (func == ALU_COMP);
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/prisc_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, R0 hard-wired to zero, every register cleared by reset.
module prisc_regfile
  import prisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rd_addr_a,
  output logic [31:0] rd_data_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_b,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] rf_view [32];

  assign rf_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      logic [31:0] reg_d;
      logic [31:0] reg_q;

      always_comb begin
        reg_d = reg_q;
        if (wr_en && (wr_addr == 5'(gi))) reg_d = wr_data;
      end

      // Reset has priority, so a write landing in the reset cycle is lost.
      always_ff @(posedge clk) begin
        if (rst) reg_q <= '0;
        else     reg_q <= reg_d;
      end

      assign rf_view[gi] = reg_q;
    end
  endgenerate

  assign rd_data_a = rf_view[rd_addr_a];
  assign rd_data_b = rf_view[rd_addr_b];

endmodule

// File: rtl/prisc_exec_ctrl.sv
// pRISC multi-cycle sequencer: fetch/decode/exec/writeback FSM, IR, pc,
// registered ALU operands, flag register and branch resolution.
module prisc_exec_ctrl
  import prisc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  output logic        instr_req,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_sign,
  input  logic        alu_carry,
  output logic [2:0]  flags,
  output logic        halted
);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [4:0]  alu_shamt_q, alu_shamt_d;
  logic [31:0] result_q, result_d;
  logic [2:0]  flags_q, flags_d;
  logic        halted_q, halted_d;

  instr_fields_t fields;
  logic [31:0]   rs_data;
  logic [31:0]   rt_data;
  logic [31:0]   imm_ext;
  logic [31:0]   pc_plus4;
  logic [31:0]   branch_target;
  logic          branch_taken;

  assign fields        = decode_fields(ir_q);
  assign imm_ext       = sext16(fields.imm);
  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + (imm_ext << 2);

  prisc_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (fields.rs),
    .rd_data_a (rs_data),
    .rd_addr_b (fields.rt),
    .rd_data_b (rt_data),
    .wr_en     (state_q == ST_WB),
    .wr_addr   (fields.rs),
    .wr_data   (result_q)
  );

  always_comb begin
    branch_taken = 1'b0;
    case (fields.opcode)
      OPC_BR:   branch_taken = 1'b1;
      OPC_BZ:   branch_taken = flags_q[FLAG_Z];
      OPC_BNZ:  branch_taken = !flags_q[FLAG_Z];
      OPC_BLTZ: branch_taken = flags_q[FLAG_S];
      OPC_BCY:  branch_taken = flags_q[FLAG_C];
      default:  branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_shamt_d = alu_shamt_q;
    result_d    = result_q;
    flags_d     = flags_q;
    halted_d    = halted_q;

    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (fields.opcode)
          OPC_RTYPE: begin
            if (func_is_legal(fields.func)) begin
              alu_op_d    = fields.func;
              alu_a_d     = rs_data;
              alu_b_d     = rt_data;
              alu_shamt_d = fields.shamt;
              state_d     = ST_EXEC;
            end else begin
              halted_d = 1'b1;
              state_d  = ST_HALT;
            end
          end
          OPC_ADDI: begin
            alu_op_d    = ALU_ADD;
            alu_a_d     = rs_data;
            alu_b_d     = imm_ext;
            alu_shamt_d = fields.shamt;
            state_d     = ST_EXEC;
          end
          OPC_BR, OPC_BZ, OPC_BNZ, OPC_BLTZ, OPC_BCY: begin
            pc_d    = branch_taken ? branch_target : pc_plus4;
            state_d = ST_FETCH;
          end
          default: begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
        endcase
      end

      ST_EXEC: begin
        result_d        = alu_result;
        flags_d[FLAG_Z] = alu_zero;
        flags_d[FLAG_S] = alu_sign;
        // Carry only means something for ADD; other ops leave C alone.
        if (alu_op_q == ALU_ADD) flags_d[FLAG_C] = alu_carry;
        state_d = ST_WB;
      end

      ST_WB: begin
        pc_d    = pc_plus4;
        state_d = ST_FETCH;
      end

      ST_HALT: begin
        halted_d = 1'b1;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_shamt_q <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_shamt_q <= alu_shamt_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      halted_q    <= halted_d;
    end
  end

  // Request is masked while reset is held so memory never sees a stale fetch.
  assign instr_req = (state_q == ST_FETCH) && !rst;
  assign pc        = pc_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_shamt = alu_shamt_q;
  assign flags     = flags_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_prisc_exec_ctrl.sv
// Randomised self-checking bench for prisc_exec_ctrl: an ISA-level model
// tracks registers, flags and pc; a behavioural ALU closes the loop.
`timescale 1ns/1ps
module tb_prisc_exec_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        instr_req;
  logic        instr_valid;
  logic [31:0] instr;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_sign;
  logic        alu_carry;
  logic [2:0]  flags;
  logic        halted;

  always #5 clk = ~clk;

  prisc_exec_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instr_req(instr_req),
    .instr_valid(instr_valid), .instr(instr), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .alu_carry(alu_carry), .flags(flags), .halted(halted)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Behavioural ALU: returns {carry, result}.
  function automatic logic [32:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    logic [4:0]  amt;
    logic [32:0] r;
    amt = op[2] ? sh : b[4:0];
    r = 33'd0;
    if (op == 4'b0001)      r = {1'b0, a} + {1'b0, b};
    else if (op == 4'b0010) r = {1'b0, a & b};
    else if (op == 4'b0011) r = {1'b0, a ^ b};
    else if (op == 4'b0101) r = {1'b0, 32'd0 - b};
    else if (op[3]) begin
      if (!op[1])     r = {1'b0, a << amt};
      else if (op[0]) r = {1'b0, 32'($signed(a) >>> amt)};
      else            r = {1'b0, a >> amt};
    end
    return r;
  endfunction

  // Non-ADD carry is driven opposite to the current C so any wrongful load shows.
  always_comb begin
    logic [32:0] r;
    r          = alu_fn(alu_op, alu_a, alu_b, alu_shamt);
    alu_result = r[31:0];
    alu_zero   = (r[31:0] == 32'd0);
    alu_sign   = r[31];
    alu_carry  = (alu_op == 4'b0001) ? r[32] : ~flags[2];
  end

  // ISA-level reference state
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic [2:0]  m_flags;   // {C,S,Z}

  logic [31:0] last_a;
  logic [3:0]  last_op;
  logic [4:0]  last_sh;

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [15:0] imm);
    return {opc, rs, 5'd0, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] sh, input logic [3:0] fn);
    return {6'd0, rs, rt, 5'd0, sh, 2'd0, fn};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc    = RST_PC;
    m_flags = 3'b000;
  endtask

  // Applies one instruction to the model; exp_lat = 4 ALU, 2 branch, 0 halt.
  task automatic model_exec(input logic [31:0] w, output int exp_lat,
                            output logic [3:0] e_op, output logic [31:0] e_a,
                            output logic [31:0] e_b, output logic [4:0] e_sh);
    logic [5:0]  opc;
    logic [4:0]  rs, rt;
    logic [3:0]  fn;
    logic [31:0] imm;
    logic [32:0] r;
    logic        is_alu, taken;
    opc = w[31:26]; rs = w[25:21]; rt = w[20:16]; fn = w[3:0];
    imm = {{16{w[15]}}, w[15:0]};
    e_sh = w[10:6]; e_op = 4'd0; e_a = 32'd0; e_b = 32'd0;
    is_alu = 1'b0; exp_lat = 0;
    if (opc == 6'd0 && (fn[3] || fn == 4'd1 || fn == 4'd2 || fn == 4'd3 || fn == 4'd5)) begin
      is_alu = 1'b1; e_op = fn; e_a = m_regs[rs]; e_b = m_regs[rt];
    end else if (opc == 6'd1) begin
      is_alu = 1'b1; e_op = 4'd1; e_a = m_regs[rs]; e_b = imm;
    end else if (opc >= 6'd2 && opc <= 6'd6) begin
      case (opc)
        6'd2:    taken = 1'b1;
        6'd3:    taken = m_flags[0];
        6'd4:    taken = !m_flags[0];
        6'd5:    taken = m_flags[1];
        default: taken = m_flags[2];
      endcase
      m_pc = taken ? m_pc + 32'd4 + (imm * 4) : m_pc + 32'd4;
      exp_lat = 2;
    end
    if (is_alu) begin
      r = alu_fn(e_op, e_a, e_b, e_sh);
      if (rs != 5'd0) m_regs[rs] = r[31:0];
      m_flags[0] = (r[31:0] == 32'd0);
      m_flags[1] = r[31];
      if (e_op == 4'd1) m_flags[2] = r[32];
      m_pc = m_pc + 32'd4;
      exp_lat = 4;
    end
  endtask

  // Issues one instruction from a negedge, returns at the negedge where the
  // next FETCH is visible (or after a fixed window for a halt).
  task automatic do_instr(input logic [31:0] w, input int delay);
    int          exp_lat, k, wait_n;
    logic [3:0]  e_op;
    logic [31:0] e_a, e_b, pc0;
    logic [4:0]  e_sh;
    logic        done;
    wait_n = 0;
    while (!instr_req && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check_eq("req_wait", 32'(instr_req), 32'd1);
    check_eq("pc_fetch", pc, m_pc);
    pc0 = pc;
    for (int i = 0; i < delay; i++) begin
      instr_valid = 1'b0;
      instr = $urandom;
      @(negedge clk);
      check_eq("hold_pc", pc, pc0);
      check_eq("hold_req", 32'(instr_req), 32'd1);
      check_eq("hold_flags", 32'(flags), 32'(m_flags));
    end
    model_exec(w, exp_lat, e_op, e_a, e_b, e_sh);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 1;
    done = 1'b0;
    while (k < 8 && !done) begin
      if (instr_req) done = 1'b1;
      else begin
        if (exp_lat == 4 && (k == 2 || k == 3)) begin
          check_eq("alu_op", 32'(alu_op), 32'(e_op));
          check_eq("alu_a", alu_a, e_a);
          check_eq("alu_b", alu_b, e_b);
          check_eq("alu_shamt", 32'(alu_shamt), 32'(e_sh));
          if (k == 2) begin
            last_a = alu_a; last_op = alu_op; last_sh = alu_shamt;
          end
        end
        instr_valid = 1'($urandom_range(0, 1));
        instr = $urandom;
        @(negedge clk);
        k++;
      end
    end
    instr_valid = 1'b0;
    if (exp_lat != 0) begin
      check_eq("latency", 32'(k), 32'(exp_lat));
      check_eq("pc_next", pc, m_pc);
      check_eq("flags", 32'(flags), 32'(m_flags));
      check_eq("halted", 32'(halted), 32'd0);
    end else begin
      check_eq("halt_req", 32'(instr_req), 32'd0);
      check_eq("halt_flag", 32'(halted), 32'd1);
      check_eq("halt_flags", 32'(flags), 32'(m_flags));
    end
    $display("instr pc=%08h w=%08h lat=%0d flags=%03b pc_next=%08h", pc0, w, k, flags, pc);
  endtask

  task automatic readback(input int rx, input logic [31:0] expv, input string tag);
    do_instr(enc_r(5'(rx), 5'(rx), 5'd0, 4'b0010), 0);
    check_eq(tag, last_a, expv);
  endtask

  task automatic check_reset_state();
    check_eq("rst_pc", pc, RST_PC);
    check_eq("rst_req", 32'(instr_req), 32'd1);
    check_eq("rst_flags", 32'(flags), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_alu_op", 32'(alu_op), 32'd0);
    check_eq("rst_alu_a", alu_a, 32'd0);
    check_eq("rst_alu_b", alu_b, 32'd0);
    check_eq("rst_shamt", 32'(alu_shamt), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_req_low", 32'(instr_req), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    check_reset_state();
    $display("reset pc=%08h", pc);
  endtask

  // Reset lands while an ADDI is in EXEC (at_k=2) or WB (at_k=3).
  task automatic reset_midflight(input int at_k);
    instr = enc_i(6'd1, 5'd5, 16'h0077);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    for (int i = 1; i < at_k; i++) @(negedge clk);
    do_reset();
    $display("reset mid-flight at stage %0d", at_k);
  endtask

  logic [3:0] legal_tbl [4];

  initial begin
    logic [31:0] w;
    int          sel, fi;
    legal_tbl[0] = 4'd1; legal_tbl[1] = 4'd2; legal_tbl[2] = 4'd3; legal_tbl[3] = 4'd5;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = 32'd0;
    repeat (2) @(negedge clk);
    do_reset();

    // Basic ADDI and carry-flag sequence
    do_instr(32'h0420_0005, 0);
    check_eq("addi_flags", 32'(flags), 32'b000);
    check_eq("addi_pc", pc, 32'h104);
    readback(1, 32'd5, "r1_eq5");
    do_instr(enc_i(6'd1, 5'd2, 16'hFFFF), 0);
    check_eq("c_seq1", 32'(flags), 32'b010);
    do_instr(enc_i(6'd1, 5'd2, 16'h0001), 0);
    check_eq("c_seq2", 32'(flags), 32'b101);
    do_instr(enc_r(5'd2, 5'd2, 5'd0, 4'b0011), 0);
    check_eq("c_seq3", 32'(flags), 32'b101);

    // Branches from pc 0x10 with Z=1
    do_instr(enc_i(6'd2, 5'd0, 16'((32'h10 - m_pc - 32'd4) >> 2)), 0);
    check_eq("br_to_10", pc, 32'h10);
    do_instr(enc_i(6'd3, 5'd0, 16'd3), 0);
    check_eq("bz_taken", pc, 32'h20);
    do_instr(enc_i(6'd2, 5'd0, 16'hFFFB), 0);
    do_instr(enc_i(6'd4, 5'd0, 16'd3), 0);
    check_eq("bnz_not", pc, 32'h14);
    check_eq("br_flags", 32'(flags), 32'b101);

    // Fetch stall of 5 cycles, shift by shamt, R0 write discard
    do_instr(enc_i(6'd1, 5'd3, 16'hFFFF), 5);
    do_instr(enc_r(5'd3, 5'd0, 5'd4, 4'b1110), 0);
    check_eq("shr_op", 32'(last_op), 32'he);
    check_eq("shr_sh", 32'(last_sh), 32'd4);
    readback(3, 32'h0FFF_FFFF, "r3_shr");
    do_instr(enc_i(6'd1, 5'd0, 16'd7), 0);
    readback(0, 32'd0, "r0_zero");

    // Randomised mix on a small register window to create dependencies
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        case ($urandom_range(0, 3))
          0:       w = enc_i(6'd1, 5'($urandom_range(0, 7)), 16'hFFFF);
          1:       w = enc_i(6'd1, 5'($urandom_range(0, 7)), 16'h8000);
          default: w = enc_i(6'd1, 5'($urandom_range(0, 7)), 16'($urandom));
        endcase
      end else if (sel <= 6) begin
        fi = $urandom_range(0, 11);
        w = enc_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 31)), (fi < 4) ? legal_tbl[fi] : 4'(fi + 4));
      end else begin
        w = enc_i(6'($urandom_range(2, 6)), 5'd0, 16'($signed(32'($urandom_range(0, 15)) - 8)));
      end
      do_instr(w, $urandom_range(0, 2));
    end

    // Reset during EXEC or WB, then every register must read zero
    do_instr(enc_i(6'd1, 5'd5, 16'h1234), 0);
    reset_midflight(int'($urandom_range(2, 3)));
    for (int r = 1; r < 32; r++) readback(r, 32'd0, "rst_reg_zero");
    do_instr(enc_i(6'd1, 5'd6, 16'h0042), 0);
    reset_midflight(3);
    readback(6, 32'd0, "wb_dropped");

    // Halt paths: HALT opcode, illegal func, illegal opcode
    do_instr(32'hFC00_0000, 0);
    repeat (5) @(negedge clk);
    check_eq("halt_sticky_req", 32'(instr_req), 32'd0);
    check_eq("halt_sticky", 32'(halted), 32'd1);
    do_reset();
    do_instr(enc_r(5'd1, 5'd2, 5'd0, 4'b0100), 0);
    do_reset();
    do_instr(enc_i(6'b001000, 5'd1, 16'd1), 0);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prisc_exec_ctrl.md
# prisc_exec_ctrl

Multi-cycle sequencer and register file for the pRISC core, sitting directly upstream of the ALU. It fetches one instruction word at a time over a valid handshake and decodes it. It presents registered operands, op code and shift amount to the ALU, then writes the ALU result back. It also owns the architectural flag register (Z, S, C) and resolves conditional branches against it.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- pc  out  32  address of the instruction being fetched or executed.
- instr_req  out  1  fetch request, high only in FETCH.
- instr_valid  in  1  instruction memory has `instr` for `pc`; ignored unless `instr_req`=1.
- instr  in  32  instruction word.
- alu_op  out  4  ALU op code, registered.
- alu_a  out  32  ALU operand A, registered.
- alu_b  out  32  ALU operand B, registered.
- alu_shamt  out  5  instruction shamt field, registered.
- alu_result  in  32  ALU result, combinational from the alu_* outputs.
- alu_zero / alu_sign / alu_carry  in  1 each  ALU flags.
- flags  out  3  {C,S,Z} flag register.
- halted  out  1  sticky; set on HALT or illegal encoding.

## Operation
- Instruction fields:
  - opcode [31:26]; rs [25:21] (source A and destination); rt [20:16]; shamt [10:6]; func [3:0]; imm [15:0], sign-extended.
- ALU op codes (fixed):
  - ADD 0001, AND 0010, XOR 0011, COMP 0101 (two's complement of B).
  - Shifts 1xxx: bit2=1 shift by shamt, else by B[4:0]; bit1=1 right; bit0=1 arithmetic.
- Opcodes:
  - 000000 R-type: alu_op=func, A=R[rs], B=R[rt]; legal func = 0001, 0010, 0011, 0101, 1000–1111.
  - 000001 ADDI: alu_op=ADD, A=R[rs], B=sext(imm).
  - 000010 BR: unconditional branch.
  - 000011 BZ (Z=1), 000100 BNZ (Z=0), 000101 BLTZ (S=1), 000110 BCY (C=1).
  - 111111 HALT.
  - Any other opcode, or an illegal func, behaves as HALT.
- Branch target = pc+4+(sext(imm)<<2); not taken or non-branch → pc+4.
- Register file: 32×32; R0 reads 0, writes to R0 discarded.
- Flags, captured at end of EXEC for R-type/ADDI:
  - Z and S always load.
  - C loads only when alu_op=ADD.
  - Branches and HALT never change flags.
- States: FETCH → DECODE → EXEC → WB → FETCH; DECODE → FETCH for branches; DECODE → HALT.
  - FETCH: instr_req=1; on instr_valid latch IR, go DECODE; otherwise hold with pc stable.
  - DECODE: read R[rs], R[rt]; load alu_op/alu_a/alu_b/alu_shamt registers. A branch updates pc here and returns to FETCH.
  - EXEC: alu_* stable; capture alu_result into the result register and update flags.
  - WB: R[rs] ← result; pc ← pc+4.
  - HALT: instr_req=0, halted=1; only rst exits.

## Timing
- Reset (any state, including mid-EXEC/WB):
  - Next cycle state=FETCH, pc=RESET_PC.
  - All registers 0, flags=0, halted=0, alu_op=0000, alu_a=alu_b=0, alu_shamt=0.
  - instr_req=0 during the rst cycle and 1 in the first cycle after rst deasserts.
  - An in-flight WB write is dropped.
- ALU instruction: 4 cycles when instr_valid is already high in FETCH. Branch: 2 cycles. Each FETCH wait cycle adds one.
- alu_* outputs change only on the DECODE→EXEC edge and hold through WB.
- Flags used by a branch are those left by the last completed ALU instruction; no forwarding is needed.
- Back-to-back dependency needs no hazard logic: WB completes before the next DECODE.

## Structure
- Package `prisc_pkg`: opcode and func constants, ALU op codes, state encoding, instruction field bit positions, flag bit indices.
- Sub-module `prisc_regfile`: 32×32, two combinational read ports, one synchronous write port, R0 forced to zero.
- All sequencing, IR, flag register and pc stay in `prisc_exec_ctrl`.

## Test plan
- Reset with RESET_PC=0x100, then ADDI r1,5 (0x04200005) → pc=0x100 on the first FETCH. WB writes r1=5; flags Z=0, S=0, C=0; pc=0x104.
- Carry flag sequence:
  - ADDI r2,0xFFFF → r2=0xFFFFFFFF, S=1, C=0.
  - ADDI r2,1 → r2=0, Z=1, C=1.
  - R-type XOR r2,r2 → Z=1, C stays 1.
- With Z=1 at pc=0x10, BZ imm=3 → next fetch pc=0x20 two cycles after acceptance. BNZ at the same pc → pc=0x14. Flags unchanged.
- Hold instr_valid low for 5 FETCH cycles → instr_req high, pc stable, no register or flag change. Pulse instr_valid while in EXEC → ignored.
- r3=0xFFFFFFFF, R-type func 1110 with shamt=4 → alu_op=1110, alu_shamt=4, r3=0x0FFFFFFF.
- Reset and halt cases:
  - ADDI r0,7 → r0 still reads 0.
  - Opcode 111111 → halted=1, instr_req=0 permanently.
  - Assert rst mid-EXEC → pc=RESET_PC, halted=0, r1–r31=0.
